// File: rtl/mem_arb_pkg.sv
// Shared constants and response-stage state for the data-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DMEM_ADDR_W = 14;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STRB_W      = 4;
    localparam int unsigned NUM_PORTS   = 2;
    localparam int unsigned CTR_W       = 8;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_DBG = 1;

    localparam logic [STRB_W-1:0] WSTRB_READ = 4'b0000;

    // One in-flight access waiting for its response cycle.
    typedef struct packed {
        logic pending;
        logic owner;
        logic is_write;
    } rsp_state_t;

    function automatic logic strb_is_write(input logic [STRB_W-1:0] strb);
        return strb != WSTRB_READ;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating wait counter for the low-priority port; raises force once the
// port has been blocked for STARVE_LIMIT consecutive cycles.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_valid,
    input  logic granted,
    output logic force_o
);

    localparam logic [CTR_W-1:0] LIMIT = CTR_W'(STARVE_LIMIT);

    logic [CTR_W-1:0] cnt_q, cnt_d;
    logic             force_q, force_d;

    // Clear on grant or withdrawal, otherwise count up and stick at the limit.
    always_comb begin
        cnt_d   = cnt_q;
        force_d = 1'b0;
        if (!wait_valid || granted) begin
            cnt_d = '0;
        end else if (cnt_q < LIMIT) begin
            cnt_d = cnt_q + CTR_W'(1);
        end
        force_d = (cnt_d == LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            force_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            force_q <= force_d;
        end
    end

    assign force_o = force_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single synchronous data-memory port: fixed CPU
// priority with a starvation override for the debug/loader port.
module dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DMEM_ADDR_W,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_valid,
    output logic [NUM_PORTS-1:0] req_ready,
    input  logic [ADDR_W-1:0]    req_addr0,
    input  logic [ADDR_W-1:0]    req_addr1,
    input  logic [DATA_W-1:0]    req_wdata0,
    input  logic [DATA_W-1:0]    req_wdata1,
    input  logic [STRB_W-1:0]    req_wstrb0,
    input  logic [STRB_W-1:0]    req_wstrb1,
    output logic [NUM_PORTS-1:0] rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 mem_en,
    output logic [STRB_W-1:0]    mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata
);

    logic       force_dbg;
    rsp_state_t rsp_q, rsp_d;

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .wait_valid (req_valid[PORT_DBG]),
        .granted    (req_ready[PORT_DBG]),
        .force_o    (force_dbg)
    );

    // Grant: debug port only when the CPU is idle or the force flag is up.
    always_comb begin
        req_ready = '0;
        if (rst_n) begin
            if (req_valid[PORT_DBG] && (!req_valid[PORT_CPU] || force_dbg)) begin
                req_ready[PORT_DBG] = 1'b1;
            end else if (req_valid[PORT_CPU]) begin
                req_ready[PORT_CPU] = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = WSTRB_READ;
        mem_addr  = '0;
        mem_wdata = '0;
        if (req_ready[PORT_CPU]) begin
            mem_en    = 1'b1;
            mem_we    = req_wstrb0;
            mem_addr  = req_addr0;
            mem_wdata = req_wdata0;
        end else if (req_ready[PORT_DBG]) begin
            mem_en    = 1'b1;
            mem_we    = req_wstrb1;
            mem_addr  = req_addr1;
            mem_wdata = req_wdata1;
        end
    end

    always_comb begin
        rsp_d          = '0;
        rsp_d.pending  = mem_en;
        rsp_d.owner    = req_ready[PORT_DBG];
        rsp_d.is_write = strb_is_write(mem_we);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    // Writes are acknowledged with zero data; reads pass the memory word through.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (rsp_q.pending) begin
            rsp_valid[rsp_q.owner] = 1'b1;
            if (!rsp_q.is_write) begin
                rsp_rdata = mem_rdata;
            end
        end
    end

endmodule
